// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ID/EX ALU-control stage: ALU codes, MIPS
// opcode/funct encodings and the control bundle carried into EX.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_BEQ  = 4'b0110;
    localparam logic [3:0] ALU_BNE  = 4'b0111;
    localparam logic [3:0] ALU_BGEZ = 4'b1111;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [4:0] RT_BGEZ = 5'b00001;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic        alu_src_imm;
        logic        swap_ops;
        logic [31:0] imm;
        logic        is_branch;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  dst_reg;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '{
        alu_ctrl:    ALU_ADD,
        alu_src_imm: 1'b0,
        swap_ops:    1'b0,
        imm:         32'h0,
        is_branch:   1'b0,
        reg_write:   1'b0,
        mem_read:    1'b0,
        mem_write:   1'b0,
        dst_reg:     5'd0
    };

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// ID-side request and EX-side control outputs of the ALU-control stage.
interface alu_ctrl_stage_if #(
    parameter int ILLEGAL_CNT_W = 8
);
    logic                     id_valid;
    logic [31:0]              id_instr;
    logic                     stall;
    logic                     flush;
    logic                     ex_valid;
    logic [3:0]               ex_alu_ctrl;
    logic                     ex_alu_src_imm;
    logic                     ex_swap_ops;
    logic [31:0]              ex_imm;
    logic                     ex_is_branch;
    logic                     ex_reg_write;
    logic                     ex_mem_read;
    logic                     ex_mem_write;
    logic [4:0]               ex_dst_reg;
    logic                     ex_illegal;
    logic [ILLEGAL_CNT_W-1:0] illegal_count;

    modport master (
        output id_valid, id_instr, stall, flush,
        input  ex_valid, ex_alu_ctrl, ex_alu_src_imm, ex_swap_ops, ex_imm,
               ex_is_branch, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_dst_reg, ex_illegal, illegal_count
    );

    modport slave (
        input  id_valid, id_instr, stall, flush,
        output ex_valid, ex_alu_ctrl, ex_alu_src_imm, ex_swap_ops, ex_imm,
               ex_is_branch, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_dst_reg, ex_illegal, illegal_count
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS decode: instruction word to EX control bundle plus an
// illegal-encoding flag. Illegal encodings yield the bubble bundle.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic signed [15:0] imm16_s;
    logic signed [31:0] imm_sext;
    logic [31:0]        imm_zext;
    logic [4:0]         unused_rs;

    assign opcode    = instr_i[31:26];
    assign unused_rs = instr_i[25:21];
    assign rt        = instr_i[20:16];
    assign rd        = instr_i[15:11];
    assign funct     = instr_i[5:0];
    assign imm16_s   = instr_i[15:0];
    assign imm_sext  = 32'(imm16_s);
    assign imm_zext  = {16'h0000, instr_i[15:0]};

    // Stores and branches name no destination, so dst_reg stays 0 for them.
    always_comb begin
        ctrl_o    = BUBBLE_CTRL;
        illegal_o = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dst_reg   = rd;
                case (funct)
                    FN_ADD: ctrl_o.alu_ctrl = ALU_ADD;
                    FN_SUB: ctrl_o.alu_ctrl = ALU_SUB;
                    FN_AND: ctrl_o.alu_ctrl = ALU_AND;
                    FN_OR:  ctrl_o.alu_ctrl = ALU_OR;
                    FN_NOR: ctrl_o.alu_ctrl = ALU_NOR;
                    FN_SLT: begin
                        ctrl_o.alu_ctrl = ALU_SLT;
                        ctrl_o.swap_ops = 1'b1;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                ctrl_o.alu_src_imm = 1'b1;
                ctrl_o.reg_write   = 1'b1;
                ctrl_o.dst_reg     = rt;
                case (opcode)
                    OP_ANDI: begin
                        ctrl_o.alu_ctrl = ALU_AND;
                        ctrl_o.imm      = imm_zext;
                    end
                    OP_ORI: begin
                        ctrl_o.alu_ctrl = ALU_OR;
                        ctrl_o.imm      = imm_zext;
                    end
                    OP_SLTI: begin
                        ctrl_o.alu_ctrl = ALU_SLT;
                        ctrl_o.swap_ops = 1'b1;
                        ctrl_o.imm      = imm_sext;
                    end
                    default: begin
                        ctrl_o.alu_ctrl = ALU_ADD;
                        ctrl_o.imm      = imm_sext;
                    end
                endcase
            end
            OP_LW: begin
                ctrl_o.alu_src_imm = 1'b1;
                ctrl_o.imm         = imm_sext;
                ctrl_o.mem_read    = 1'b1;
                ctrl_o.reg_write   = 1'b1;
                ctrl_o.dst_reg     = rt;
            end
            OP_SW: begin
                ctrl_o.alu_src_imm = 1'b1;
                ctrl_o.imm         = imm_sext;
                ctrl_o.mem_write   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o.is_branch = 1'b1;
                ctrl_o.imm       = imm_sext;
                ctrl_o.alu_ctrl  = (opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
            end
            OP_REGIMM: begin
                if (rt == RT_BGEZ) begin
                    ctrl_o.is_branch = 1'b1;
                    ctrl_o.imm       = imm_sext;
                    ctrl_o.alu_ctrl  = ALU_BGEZ;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o) begin
            ctrl_o = BUBBLE_CTRL;
        end
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX pipeline register for ALU control: decode, then register with
// flush > stall > load priority and a saturating illegal-instruction count.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int ILLEGAL_CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_ctrl_stage_if.slave bus
);

    localparam logic [ILLEGAL_CNT_W-1:0] CNT_ONE = {{(ILLEGAL_CNT_W-1){1'b0}}, 1'b1};

    ctrl_t                     dec_ctrl;
    logic                      dec_illegal;
    ctrl_t                     ctrl_d,    ctrl_q;
    logic                      valid_d,   valid_q;
    logic                      illegal_d, illegal_q;
    logic [ILLEGAL_CNT_W-1:0]  cnt_d,     cnt_q;

    function automatic logic [ILLEGAL_CNT_W-1:0] sat_inc(input logic [ILLEGAL_CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    alu_ctrl_decode u_decode (
        .instr_i   (bus.id_instr),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // ex_illegal is a pulse, so it drops on stall and flush rather than holding.
    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        illegal_d = 1'b0;
        cnt_d     = cnt_q;
        if (bus.flush) begin
            ctrl_d  = BUBBLE_CTRL;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            if (bus.id_valid && !dec_illegal) begin
                ctrl_d  = dec_ctrl;
                valid_d = 1'b1;
            end else begin
                ctrl_d  = BUBBLE_CTRL;
                valid_d = 1'b0;
            end
            if (bus.id_valid && dec_illegal) begin
                illegal_d = 1'b1;
                cnt_d     = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= BUBBLE_CTRL;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.ex_valid       = valid_q;
    assign bus.ex_alu_ctrl    = ctrl_q.alu_ctrl;
    assign bus.ex_alu_src_imm = ctrl_q.alu_src_imm;
    assign bus.ex_swap_ops    = ctrl_q.swap_ops;
    assign bus.ex_imm         = ctrl_q.imm;
    assign bus.ex_is_branch   = ctrl_q.is_branch;
    assign bus.ex_reg_write   = ctrl_q.reg_write;
    assign bus.ex_mem_read    = ctrl_q.mem_read;
    assign bus.ex_mem_write   = ctrl_q.mem_write;
    assign bus.ex_dst_reg     = ctrl_q.dst_reg;
    assign bus.ex_illegal     = illegal_q;
    assign bus.illegal_count  = cnt_q;

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Instruction-decode-side producer of the 4-bit ALU control code and operand steering for the EX stage.
- Decodes the MIPS opcode/funct of the ID-stage instruction into alu_ctrl, immediate and control bits, then registers them as the ID/EX pipeline register.
- Supports stall (hold) and flush (bubble).
- Flags illegal encodings and keeps a saturating count of them.

Parameters:
- ILLEGAL_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  id_instr holds a real instruction this cycle
- id_instr  in  32  instruction word from IF/ID
- stall  in  1  hold all EX outputs unchanged
- flush  in  1  load a bubble next edge
- ex_valid  out  1  EX slot holds a real instruction
- ex_alu_ctrl  out  4  ALU operation code
- ex_alu_src_imm  out  1  ALU operand 2 = ex_imm, not rt
- ex_swap_ops  out  1  swap ALU operands (used for SLT forms)
- ex_imm  out  32  extended immediate
- ex_is_branch  out  1  instruction is beq/bne/bgez
- ex_reg_write  out  1  writes the register file
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_dst_reg  out  5  destination register: rd for R-type, rt for I-type
- ex_illegal  out  1  one-cycle pulse: the instruction just loaded was illegal
- illegal_count  out  ILLEGAL_CNT_W  saturating count of illegal instructions

Behaviour:
- ALU codes: ADD 0000, SUB 0001, AND 0010, NOR 0011, OR 0100, SLT 0101, BEQ 0110, BNE 0111, BGEZ 1111.
  - ALU SLT computes op1 > op2, so slt/slti assert swap_ops to yield rs < rt (or rs < imm).
- Decode, opcode 000000 (R-type) by funct:
  - 100000 → ADD
  - 100010 → SUB
  - 100100 → AND
  - 100101 → OR
  - 100111 → NOR
  - 101010 → SLT with swap
  - reg_write=1, dst=rd.
- Decode, I-type (src_imm=1, reg_write=1, dst=rt):
  - addi 001000 → ADD, sign-extended imm
  - andi 001100 → AND, zero-extended imm
  - ori 001101 → OR, zero-extended imm
  - slti 001010 → SLT, swap, sign-extended imm
- Decode, memory (ADD, src_imm=1, sign-extended imm):
  - lw 100011: mem_read=1, reg_write=1, dst=rt.
  - sw 101011: mem_write=1, reg_write=0.
- Decode, branches (is_branch=1, reg_write=0, src_imm=0, imm sign-extended):
  - beq 000100 → BEQ
  - bne 000101 → BNE
  - bgez: opcode 000001 with rt=00001 → BGEZ; operand 2 forced to zero is the EX mux's job.
- Any other opcode, funct, or REGIMM rt is illegal.
- Latency: one cycle. Outputs reflect id_instr sampled on the previous rising edge.
- Bubble:
  - ex_valid=0, alu_ctrl=ADD, all control bits 0, imm=0, dst=0.
  - Reset, flush, !id_valid and illegal instructions all load a bubble.
- Priority at each edge: flush > stall > load.
  - flush with stall high still loads a bubble.
  - stall alone holds every output, including illegal_count.
  - ex_illegal deasserts during stall; no double count.
- Illegal instruction (id_valid=1, not stalled, not flushed):
  - ex_illegal=1 for one cycle and the EX slot is a bubble.
  - illegal_count increments and saturates at 2^ILLEGAL_CNT_W−1, no wrap.
- Reset (asynchronous, any time, including mid-stall):
  - all outputs go to bubble values immediately.
  - ex_illegal=0, illegal_count=0.
  - first load on the first edge after rst_n rises.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package alu_ctrl_pkg: ALU code localparams, opcode/funct/REGIMM-rt constants, bubble default values.
- Sub-module alu_ctrl_decode: purely combinational instr → control bundle plus illegal flag.
- alu_ctrl_stage wraps alu_ctrl_decode with the register, stall/flush priority and counter.

Test Plan:
- Reset then `add $3,$1,$2` (0x00221820), id_valid=1 → next cycle: ex_valid=1, alu_ctrl=0000, reg_write=1, dst=3, src_imm=0.
- `andi $4,$5,0xFFFF` → imm=0x0000FFFF, alu_ctrl=0010, src_imm=1. `addi` with imm 0xFFFF → imm=0xFFFFFFFF.
- `slt` (funct 101010) → alu_ctrl=0101, swap_ops=1. `bgez` (opcode 000001, rt=1) → alu_ctrl=1111, is_branch=1, reg_write=0.
- Load lw, then hold stall=1 for 3 cycles while id_instr changes → outputs frozen at the lw values. Then flush=1 with stall=1 → bubble, ex_valid=0.
- Opcode 111111 presented 300 times with no stall (ILLEGAL_CNT_W=8) → ex_illegal pulses each cycle, ex_valid=0, illegal_count saturates at 255.
- Assert rst_n=0 mid-cycle with a valid instruction loaded → outputs go to bubble and count=0 without waiting for a clock edge.
